// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - time-shares one square-wave tone generator between four sound effects
// Effects are hard-wired note lists; DEATH preempts on tick boundaries, loops yield only at note boundaries.
module sound_sequencer #(
    parameter int TICK_DIV   = 25000,
    parameter int NOTE_TICKS = 40,
    parameter int GAP_TICKS  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic        pause,
    input  logic        death_trig,
    input  logic        eat_ghost_trig,
    input  logic        fright_active,
    input  logic        move_active,
    output logic        tone_en,
    output logic [11:0] tone_half_period,
    output logic [1:0]  active_src,
    output logic        busy,
    output logic        death_done
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(NOTE_TICKS + GAP_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] NOTE_LAST = PW'(NOTE_TICKS - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [1:0] SRC_DEATH  = 2'd0;
    localparam logic [1:0] SRC_EAT    = 2'd1;
    localparam logic [1:0] SRC_FRIGHT = 2'd2;
    localparam logic [1:0] SRC_MOVE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NOTE,
        S_GAP
    } state_t;

    function automatic logic [11:0] note_rom(input logic [1:0] s, input logic [2:0] i);
        logic [11:0] h;
        h = 12'd0;
        case (s)
            SRC_DEATH: begin
                case (i)
                    3'd0:    h = 12'd1136;
                    3'd1:    h = 12'd1204;
                    3'd2:    h = 12'd1276;
                    3'd3:    h = 12'd1351;
                    3'd4:    h = 12'd1432;
                    3'd5:    h = 12'd1517;
                    3'd6:    h = 12'd1607;
                    default: h = 12'd1703;
                endcase
            end
            SRC_EAT: begin
                case (i[1:0])
                    2'd0:    h = 12'd758;
                    2'd1:    h = 12'd676;
                    2'd2:    h = 12'd602;
                    default: h = 12'd568;
                endcase
            end
            SRC_FRIGHT: h = i[0] ? 12'd1911 : 12'd2024;
            default:    h = i[0] ? 12'd1136 : 12'd1516;
        endcase
        return h;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] s);
        return (s == SRC_DEATH) ? 3'd7 : 3'd3;
    endfunction

    state_t        state;
    logic [1:0]    src;
    logic [2:0]    idx;
    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] phase_cnt;
    logic          death_pend;
    logic [1:0]    eat_cnt;

    logic       tick;
    logic       death_playing;
    logic       req_any;
    logic [1:0] req_src;
    logic       note_end;
    logic       gap_end;
    logic       do_start;
    logic [1:0] start_src;
    logic [2:0] start_idx;
    logic       go_gap;
    logic       go_idle;
    logic       done_now;
    logic       eat_dec;
    logic       death_start;

    always_comb begin
        tick          = !pause && (state != S_IDLE) && (tick_cnt == TICK_LAST);
        death_playing = (state != S_IDLE) && (src == SRC_DEATH);
        req_any       = death_pend || (eat_cnt != 2'd0) || fright_active || move_active;
        if (death_pend)
            req_src = SRC_DEATH;
        else if (eat_cnt != 2'd0)
            req_src = SRC_EAT;
        else if (fright_active)
            req_src = SRC_FRIGHT;
        else
            req_src = SRC_MOVE;
        note_end  = (state == S_NOTE) && (phase_cnt == NOTE_LAST);
        gap_end   = (state == S_GAP) && (phase_cnt == GAP_LAST);
        do_start  = 1'b0;
        start_src = src;
        start_idx = idx;
        go_gap    = 1'b0;
        go_idle   = 1'b0;
        done_now  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!pause && req_any) begin
                    do_start  = 1'b1;
                    start_src = req_src;
                    start_idx = 3'd0;
                end
            end
            default: begin
                if (tick) begin
                    if (death_pend && (src != SRC_DEATH)) begin
                        do_start  = 1'b1;
                        start_src = SRC_DEATH;
                        start_idx = 3'd0;
                    end else if (note_end && (GAP_TICKS != 0)) begin
                        go_gap = 1'b1;
                    end else if (note_end || gap_end) begin
                        if ((src == SRC_DEATH) || (src == SRC_EAT)) begin
                            if (idx != last_idx(src)) begin
                                do_start  = 1'b1;
                                start_idx = idx + 3'd1;
                            end else begin
                                go_idle  = 1'b1;
                                done_now = (src == SRC_DEATH);
                            end
                        end else if (req_any) begin
                            // Loop sources are re-arbitrated at every note boundary.
                            do_start  = 1'b1;
                            start_src = req_src;
                            start_idx = (req_src == src) ? {2'b00, ~idx[0]} : 3'd0;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end
                end
            end
        endcase
        eat_dec     = do_start && (start_src == SRC_EAT) && (start_idx == 3'd0);
        death_start = do_start && (start_src == SRC_DEATH) && (start_idx == 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            src              <= 2'd0;
            idx              <= 3'd0;
            tick_cnt         <= '0;
            phase_cnt        <= '0;
            death_pend       <= 1'b0;
            eat_cnt          <= 2'd0;
            tone_en          <= 1'b0;
            tone_half_period <= 12'd0;
            active_src       <= 2'd0;
            busy             <= 1'b0;
            death_done       <= 1'b0;
        end else if (restart) begin
            state            <= S_IDLE;
            src              <= 2'd0;
            idx              <= 3'd0;
            tick_cnt         <= '0;
            phase_cnt        <= '0;
            death_pend       <= 1'b0;
            eat_cnt          <= 2'd0;
            tone_en          <= 1'b0;
            tone_half_period <= 12'd0;
            active_src       <= 2'd0;
            busy             <= 1'b0;
            death_done       <= 1'b0;
        end else begin
            death_done <= done_now;

            // A trigger coinciding with DEATH completion re-arms it.
            if (done_now)
                death_pend <= death_trig;
            else if (death_trig && !death_playing)
                death_pend <= 1'b1;

            if (death_start)
                eat_cnt <= eat_ghost_trig ? 2'd1 : 2'd0;
            else if (eat_ghost_trig && !eat_dec) begin
                if (eat_cnt != 2'd3)
                    eat_cnt <= eat_cnt + 2'd1;
            end else if (!eat_ghost_trig && eat_dec)
                eat_cnt <= eat_cnt - 2'd1;

            if (do_start) begin
                state            <= S_NOTE;
                src              <= start_src;
                idx              <= start_idx;
                tick_cnt         <= '0;
                phase_cnt        <= '0;
                tone_en          <= 1'b1;
                tone_half_period <= note_rom(start_src, start_idx);
                active_src       <= start_src;
                busy             <= 1'b1;
            end else if (go_gap) begin
                state     <= S_GAP;
                tick_cnt  <= '0;
                phase_cnt <= '0;
                tone_en   <= 1'b0;
            end else if (go_idle) begin
                state            <= S_IDLE;
                tick_cnt         <= '0;
                phase_cnt        <= '0;
                tone_en          <= 1'b0;
                tone_half_period <= 12'd0;
                active_src       <= 2'd0;
                busy             <= 1'b0;
            end else begin
                if ((state != S_IDLE) && !pause) begin
                    tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                    if (tick)
                        phase_cnt <= phase_cnt + PW'(1);
                end
                tone_en <= (state == S_NOTE) && !pause;
            end
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - scoreboard bench for sound_sequencer
module tb_sound_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int NOTE_TICKS = 2;
    localparam int GAP_TICKS  = 1;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        restart        = 1'b0;
    logic        pause          = 1'b0;
    logic        death_trig     = 1'b0;
    logic        eat_ghost_trig = 1'b0;
    logic        fright_active  = 1'b0;
    logic        move_active    = 1'b0;
    logic        tone_en;
    logic [11:0] tone_half_period;
    logic [1:0]  active_src;
    logic        busy;
    logic        death_done;

    sound_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .NOTE_TICKS(NOTE_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .restart         (restart),
        .pause           (pause),
        .death_trig      (death_trig),
        .eat_ghost_trig  (eat_ghost_trig),
        .fright_active   (fright_active),
        .move_active     (move_active),
        .tone_en         (tone_en),
        .tone_half_period(tone_half_period),
        .active_src      (active_src),
        .busy            (busy),
        .death_done      (death_done)
    );

    always #5 clk = ~clk;

    // kind 0: one note (src, half, tone-on cycles, total cycles); kind 1: death_done pulse of width 'on'
    typedef struct {
        int kind;
        int src;
        int half;
        int on;
        int tot;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   death_rom[8] = '{1136, 1204, 1276, 1351, 1432, 1517, 1607, 1703};
    int   eat_rom[4]   = '{758, 676, 602, 568};

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic push_note(input int src, input int half, input int on, input int tot);
        rec_t r;
        r.kind = 0;
        r.src  = src;
        r.half = half;
        r.on   = on;
        r.tot  = tot;
        exp_q.push_back(r);
    endtask

    task automatic push_done();
        rec_t r;
        r.kind = 1;
        r.src  = 0;
        r.half = 0;
        r.on   = 1;
        r.tot  = 0;
        exp_q.push_back(r);
    endtask

    task automatic push_eat_seq();
        for (int i = 0; i < 4; i++)
            push_note(1, eat_rom[i], 8, 12);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic score(input rec_t got);
        rec_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL event_unexpected: got kind=%0d src=%0d half=%0d on=%0d cycles=%0d, expected no event",
                     got.kind, got.src, got.half, got.on, got.tot);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == got.kind && e.src == got.src && e.half == got.half && e.on == got.on && e.tot == got.tot)
                passes++;
            else
                $display("FAIL event: got kind=%0d src=%0d half=%0d on=%0d cycles=%0d expected kind=%0d src=%0d half=%0d on=%0d cycles=%0d",
                         got.kind, got.src, got.half, got.on, got.tot, e.kind, e.src, e.half, e.on, e.tot);
        end
    endtask

    logic [14:0] prev_key = '0;
    int          on_cnt   = 0;
    int          tot_cnt  = 0;
    int          done_run = 0;

    always @(negedge clk) begin : monitor
        logic [14:0] key;
        rec_t        r;
        key = {busy, active_src, tone_half_period};
        if (key !== prev_key) begin
            if (prev_key[14]) begin
                r.kind = 0;
                r.src  = int'(prev_key[13:12]);
                r.half = int'(prev_key[11:0]);
                r.on   = on_cnt;
                r.tot  = tot_cnt;
                score(r);
            end
            on_cnt  = 0;
            tot_cnt = 0;
        end
        tot_cnt++;
        if (tone_en)
            on_cnt++;
        prev_key = key;
        if (death_done) begin
            done_run++;
        end else if (done_run > 0) begin
            r.kind = 1;
            r.src  = 0;
            r.half = 0;
            r.on   = done_run;
            r.tot  = 0;
            score(r);
            done_run = 0;
        end
    end

    initial begin
        step(3);
        check("reset_tone_en", int'(tone_en), 0);
        check("reset_half", int'(tone_half_period), 0);
        check("reset_src", int'(active_src), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_death_done", int'(death_done), 0);
        reset_n = 1'b1;
        step(3);
        check("idle_busy", int'(busy), 0);

        // MOVE loop, two EAT triggers during the 1136 note, MOVE resumes afterwards
        push_note(3, 1516, 8, 12);
        push_note(3, 1136, 8, 12);
        push_eat_seq();
        push_eat_seq();
        push_note(3, 1516, 8, 12);
        move_active = 1'b1;
        check("move_c0_tone_en", int'(tone_en), 0);
        step(1);
        check("move_c1_tone_en", int'(tone_en), 1);
        check("move_c1_half", int'(tone_half_period), 1516);
        check("move_c1_src", int'(active_src), 3);
        check("move_c1_busy", int'(busy), 1);
        step(14);
        eat_ghost_trig = 1'b1;
        step(1);
        eat_ghost_trig = 1'b0;
        step(1);
        eat_ghost_trig = 1'b1;
        step(1);
        eat_ghost_trig = 1'b0;
        step(109);
        move_active = 1'b0;
        step(13);
        check("move_end_busy", int'(busy), 0);

        // DEATH preempts EAT 676 at the next tick and clears the pending EAT
        push_note(1, 758, 8, 12);
        push_note(1, 676, 4, 4);
        for (int i = 0; i < 8; i++)
            push_note(0, death_rom[i], 8, 12);
        push_done();
        eat_ghost_trig = 1'b1;
        step(2);
        eat_ghost_trig = 1'b0;
        step(13);
        death_trig = 1'b1;
        step(1);
        death_trig = 1'b0;
        step(2);
        check("preempt_half", int'(tone_half_period), 1136);
        check("preempt_src", int'(active_src), 0);
        step(96);
        check("death_done_pulse", int'(death_done), 1);
        check("death_done_busy", int'(busy), 0);
        step(1);
        check("death_done_width", int'(death_done), 0);
        step(10);
        check("death_idle_busy", int'(busy), 0);

        // pause mid-note: tone off the next cycle, remaining ticks resume afterwards
        push_note(3, 1516, 8, 32);
        move_active = 1'b1;
        step(3);
        pause = 1'b1;
        step(1);
        check("pause_tone_en", int'(tone_en), 0);
        check("pause_half_hold", int'(tone_half_period), 1516);
        step(1);
        move_active = 1'b0;
        step(18);
        pause = 1'b0;
        step(1);
        check("resume_tone_en", int'(tone_en), 1);
        step(14);
        check("pause_end_busy", int'(busy), 0);

        // five EAT triggers while paused saturate at three sequences, then FRIGHT
        for (int k = 0; k < 3; k++)
            push_eat_seq();
        push_note(2, 2024, 8, 12);
        push_note(2, 1911, 8, 12);
        pause = 1'b1;
        fright_active = 1'b1;
        step(1);
        eat_ghost_trig = 1'b1;
        step(5);
        eat_ghost_trig = 1'b0;
        step(2);
        check("paused_idle_busy", int'(busy), 0);
        pause = 1'b0;
        step(1);
        check("sat_first_half", int'(tone_half_period), 758);
        check("sat_first_src", int'(active_src), 1);
        step(161);
        fright_active = 1'b0;
        step(20);
        check("fright_end_busy", int'(busy), 0);

        // restart during DEATH note 3 drops simultaneous triggers and never pulses death_done
        for (int i = 0; i < 3; i++)
            push_note(0, death_rom[i], 8, 12);
        push_note(0, 1351, 4, 4);
        death_trig = 1'b1;
        step(1);
        death_trig = 1'b0;
        step(40);
        restart = 1'b1;
        death_trig = 1'b1;
        eat_ghost_trig = 1'b1;
        step(1);
        restart = 1'b0;
        death_trig = 1'b0;
        eat_ghost_trig = 1'b0;
        check("restart_tone_en", int'(tone_en), 0);
        check("restart_half", int'(tone_half_period), 0);
        check("restart_src", int'(active_src), 0);
        check("restart_busy", int'(busy), 0);
        step(20);
        check("restart_idle_busy", int'(busy), 0);

        // asynchronous reset in the middle of DEATH note 2
        push_note(0, 1136, 8, 12);
        push_note(0, 1204, 8, 12);
        push_note(0, 1276, 3, 3);
        death_trig = 1'b1;
        step(1);
        death_trig = 1'b0;
        step(28);
        reset_n = 1'b0;
        #1;
        check("async_reset_tone_en", int'(tone_en), 0);
        check("async_reset_half", int'(tone_half_period), 0);
        check("async_reset_busy", int'(busy), 0);
        step(1);
        reset_n = 1'b1;
        step(20);
        check("post_reset_busy", int'(busy), 0);

        step(5);
        check("events_outstanding", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Arbitrates four sound-effect requests (death, eat-ghost, frightened, movement) onto one shared square-wave tone generator.
- Sequences each effect as a short hard-wired note list with fixed note and gap durations.
- Sits between game-state logic (ghost/Pacman collision and mode decoding) and the single tone/PWM output stage.
- Replaces per-effect always-on oscillators with one time-shared generator.

Parameters:
- TICK_DIV, 25000: clk cycles per timing tick (must be ≥2).
- NOTE_TICKS, 40: ticks each note is held.
- GAP_TICKS, 4: silent ticks after each note (0 = no gap state).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous clear of sequencer (level, new round)
- pause  in  1  freeze all timing, force silence
- death_trig  in  1  single-cycle pulse: Pacman caught
- eat_ghost_trig  in  1  single-cycle pulse: frightened ghost eaten
- fright_active  in  1  level: any ghost frightened
- move_active  in  1  level: Pacman position changed this frame
- tone_en  out  1  enable for tone generator
- tone_half_period  out  12  half-period of the note, in clk cycles
- active_src  out  2  0=DEATH 1=EAT 2=FRIGHT 3=MOVE (valid when busy)
- busy  out  1  FSM not IDLE
- death_done  out  1  one-cycle pulse when the last DEATH note/gap completes

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE; all counters, pending flags and outputs 0 (tone_half_period=0, active_src=0).
- Tick: tick_cnt counts 0..TICK_DIV-1 and emits tick on wrap. It is cleared to 0 whenever a note or gap starts. It holds while pause=1.
- Note ROMs (index 0 first):
  - DEATH (one-shot, 8 notes): 1136,1204,1276,1351,1432,1517,1607,1703.
  - EAT (one-shot, 4 notes): 758,676,602,568.
  - FRIGHT (loop, 2 notes): 2024,1911.
  - MOVE (loop, 2 notes): 1516,1136.
- Pending state:
  - death_pend: set by death_trig; ignored while death_pend=1 or DEATH is playing.
  - eat_cnt: 2-bit counter, saturates at 3. +1 on eat_ghost_trig, −1 when an EAT sequence starts; both in the same cycle leaves it unchanged. Cleared when DEATH starts.
- Priority (high to low): death_pend > eat_cnt≠0 > fright_active > move_active.
- FSM states: IDLE, NOTE, GAP.
  - IDLE: if any request is present in cycle N, go to NOTE with note_idx=0 and src = highest priority. Registered outputs valid at N+1: tone_en=1, tone_half_period=ROM[src][0], busy=1. No request: stay IDLE, tone_en=0.
  - NOTE: tone_en=1. After NOTE_TICKS ticks, go to GAP (or to next-note logic directly if GAP_TICKS=0).
  - GAP: tone_en=0, tone_half_period holds. After GAP_TICKS ticks, run next-note logic.
  - Next-note logic:
    - If death_pend and src≠DEATH: start DEATH idx 0.
    - Else if one-shot and idx<last: idx+1.
    - Else if one-shot and idx=last: go to IDLE. If src=DEATH, pulse death_done and clear death_pend.
    - Else (loop): re-arbitrate. Same loop source still highest: idx toggles 0/1. Different source: start it at idx 0. No request: IDLE.
  - Preemption: DEATH preempts at once on the next tick boundary (NOTE or GAP): it jumps to DEATH idx 0 with tick_cnt cleared. Nothing else preempts a one-shot. Loops yield to one-shots only at note boundaries.
- Loops are not latched: dropping fright_active/move_active mid-note finishes that note and gap, then re-arbitrates.
- pause=1: FSM, counters and idx frozen; tone_en=0 combinationally-registered (next cycle); triggers still latch. On pause release, resume the same note with the remaining ticks.
- restart=1 (sync, beats pause): next cycle FSM=IDLE, death_pend=0, eat_cnt=0, tick_cnt=0, all outputs 0. Triggers arriving while restart=1 are dropped.
- Trigger and completion in the same cycle: the trigger is latched, never lost.
- death_done must never pulse on preemption or restart.

Test Plan (TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1):
- move_active=1 held from IDLE → next cycle tone_en=1, half=1516, src=3. Note lasts 8 cycles, then 4 silent cycles, then half=1136, then alternates.
- eat_ghost_trig ×2 while MOVE loops → after the current note/gap, EAT plays 758,676,602,568 twice (eat_cnt 2→1→0), then MOVE resumes at 1516.
- death_trig mid-way through the EAT note 676 → at the next tick, half=1136, src=0, eat_cnt=0. After the 8 notes and gaps, death_done pulses for exactly 1 cycle, then IDLE.
- pause asserted for 20 cycles mid-note → tone_en=0 the cycle after; on release, same half-period resumes for the remaining ticks. Total note-on time is still 8 cycles.
- eat_ghost_trig ×5 in IDLE with fright_active=1 → eat_cnt saturates at 3. Exactly 3 EAT sequences play, then FRIGHT 2024/1911.
- restart during DEATH note 3, with reset_n toggled low once mid-sequence → outputs all 0 next cycle (async for reset_n), no death_done, and IDLE holds with no requests.
